// File: rtl/mem_bus_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_bus_arbiter_pkg                                                         |
// | Shared types for the memory bus arbiter: FSM state, grant index, msize.    |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
package mem_bus_arbiter_pkg;

   localparam int ARB_NUM_REQ = 2;
   localparam int ARB_ADDR_W  = 64;
   localparam int ARB_DATA_W  = 64;
   localparam int ARB_IDX_W   = (ARB_NUM_REQ > 1) ? $clog2(ARB_NUM_REQ) : 1;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      BUSY = 1'b1
   } arb_state_t;

   typedef logic [ARB_IDX_W-1:0] grant_idx_t;

   typedef enum logic [2:0] {
      MSIZE1 = 3'd0,
      MSIZE2 = 3'd1,
      MSIZE4 = 3'd2,
      MSIZE8 = 3'd3
   } msize_t;

   typedef logic [ARB_DATA_W/8-1:0] strobe_t;

endpackage
`default_nettype wire

// File: rtl/mem_bus_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_bus_arbiter_if                                                          |
// | Requester-side and downstream-side signals of the memory bus arbiter.      |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
interface mem_bus_arbiter_if #(
   parameter int NUM_REQ = 2,
   parameter int ADDR_W  = 64,
   parameter int DATA_W  = 64
);
   localparam int STRB_W = DATA_W / 8;
   localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   // Requester side, packed per requester (index 0 = dbus, 1 = ibus)
   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ*ADDR_W-1:0] req_addr;
   logic [NUM_REQ*3-1:0]      req_size;
   logic [NUM_REQ*STRB_W-1:0] req_strobe;
   logic [NUM_REQ*DATA_W-1:0] req_data;
   logic [NUM_REQ-1:0]        resp_addr_ok;
   logic [NUM_REQ-1:0]        resp_data_ok;
   logic [DATA_W-1:0]         resp_data;

   // Downstream memory bus
   logic                      bus_valid;
   logic [ADDR_W-1:0]         bus_addr;
   logic [2:0]                bus_size;
   logic [STRB_W-1:0]         bus_strobe;
   logic [DATA_W-1:0]         bus_data;
   logic                      bus_addr_ok;
   logic                      bus_data_ok;
   logic [DATA_W-1:0]         bus_rdata;

   logic [IDX_W-1:0]          grant_id;
   logic                      busy;

   modport master (
      input  req_valid, req_addr, req_size, req_strobe, req_data,
      input  bus_addr_ok, bus_data_ok, bus_rdata,
      output resp_addr_ok, resp_data_ok, resp_data,
      output bus_valid, bus_addr, bus_size, bus_strobe, bus_data,
      output grant_id, busy
   );

   modport slave (
      output req_valid, req_addr, req_size, req_strobe, req_data,
      output bus_addr_ok, bus_data_ok, bus_rdata,
      input  resp_addr_ok, resp_data_ok, resp_data,
      input  bus_valid, bus_addr, bus_size, bus_strobe, bus_data,
      input  grant_id, busy
   );

endinterface
`default_nettype wire

// File: rtl/mem_bus_arbiter_arb_pick.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_bus_arbiter_arb_pick                                                    |
// | Combinational picker: first valid requester at or after start, wrapping.   |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module mem_bus_arbiter_arb_pick #(
   parameter int NUM_REQ = 2,
   parameter int IDX_W   = 1
) (
   input  wire logic [NUM_REQ-1:0] req_valid,
   input  wire logic [IDX_W-1:0]   start,
   output logic      [IDX_W-1:0]   winner,
   output logic                    any_valid
);

   int idx;

   // Walk from the farthest offset down so the offset closest to start wins.
   always_comb begin
      winner    = '0;
      any_valid = |req_valid;
      idx       = 0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         idx = int'(start) + k;
         if (idx >= NUM_REQ) begin
            idx = idx - NUM_REQ;
         end
         if (req_valid[idx]) begin
            winner = IDX_W'(idx);
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_bus_arbiter                                                             |
// | Shares one memory bus among NUM_REQ requesters, one transaction at a time. |
// | Fixed priority by default; MEM_BUS_ARB_RR_EN selects round-robin.          |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module mem_bus_arbiter
   import mem_bus_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int ADDR_W  = 64,
   parameter int DATA_W  = 64
) (
   input  wire logic          clk,
   input  wire logic          reset,
   mem_bus_arbiter_if.master  mif
);

   localparam int STRB_W = DATA_W / 8;
   localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   arb_state_t          state_q, state_d;
   logic [IDX_W-1:0]    grant_q, grant_d;
   logic [IDX_W-1:0]    pick_start;
   logic [IDX_W-1:0]    pick_winner;
   logic                pick_any;
   logic                in_busy;

   logic [ADDR_W-1:0]   addr_arr   [NUM_REQ];
   logic [2:0]          size_arr   [NUM_REQ];
   logic [STRB_W-1:0]   strobe_arr [NUM_REQ];
   logic [DATA_W-1:0]   data_arr   [NUM_REQ];

   logic [NUM_REQ-1:0]  resp_addr_ok;
   logic [NUM_REQ-1:0]  resp_data_ok;
   logic [ADDR_W-1:0]   bus_addr;
   logic [2:0]          bus_size;
   logic [STRB_W-1:0]   bus_strobe;
   logic [DATA_W-1:0]   bus_data;

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
      assign addr_arr[i]   = mif.req_addr[i*ADDR_W +: ADDR_W];
      assign size_arr[i]   = mif.req_size[i*3 +: 3];
      assign strobe_arr[i] = mif.req_strobe[i*STRB_W +: STRB_W];
      assign data_arr[i]   = mif.req_data[i*DATA_W +: DATA_W];
   end

   mem_bus_arbiter_arb_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_arb_pick (
      .req_valid (mif.req_valid),
      .start     (pick_start),
      .winner    (pick_winner),
      .any_valid (pick_any)
   );

`ifdef MEM_BUS_ARB_RR_EN
   // rr_ptr_q holds last_grant+1 (mod NUM_REQ): where the next search begins.
   logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (state_q == IDLE && pick_any) begin
         if (int'(pick_winner) == NUM_REQ - 1) begin
            rr_ptr_d = '0;
         end else begin
            rr_ptr_d = pick_winner + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rr_ptr_q <= '0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
      end
   end

   assign pick_start = rr_ptr_q;
`else
   assign pick_start = '0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         grant_q <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
      end
   end

   // Grant is only loaded in IDLE, so it stays frozen for the whole of BUSY.
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      case (state_q)
         IDLE: begin
            if (pick_any) begin
               state_d = BUSY;
               grant_d = pick_winner;
            end
         end
         BUSY: begin
            if (mif.bus_data_ok) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign in_busy = (state_q == BUSY);

   always_comb begin
      resp_addr_ok = '0;
      resp_data_ok = '0;
      bus_addr     = '0;
      bus_size     = '0;
      bus_strobe   = '0;
      bus_data     = '0;
      if (in_busy) begin
         bus_addr              = addr_arr[grant_q];
         bus_size              = size_arr[grant_q];
         bus_strobe            = strobe_arr[grant_q];
         bus_data              = data_arr[grant_q];
         resp_addr_ok[grant_q] = mif.bus_addr_ok;
         resp_data_ok[grant_q] = mif.bus_data_ok;
      end
   end

   assign mif.bus_valid    = in_busy;
   assign mif.busy         = in_busy;
   assign mif.grant_id     = grant_q;
   assign mif.bus_addr     = bus_addr;
   assign mif.bus_size     = bus_size;
   assign mif.bus_strobe   = bus_strobe;
   assign mif.bus_data     = bus_data;
   assign mif.resp_addr_ok = resp_addr_ok;
   assign mif.resp_data_ok = resp_data_ok;
   assign mif.resp_data    = mif.bus_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mem_bus_arbiter                                                          |
// | Directed bench with a scoreboard on resp_data_ok and a latency-driven bus. |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_mem_bus_arbiter;
   import mem_bus_arbiter_pkg::*;

   localparam int NR = 2;
   localparam int AW = 64;
   localparam int DW = 64;

   typedef struct {
      int          id;
      logic [63:0] data;
   } exp_t;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   int          checks = 0;
   int          errors = 0;
   exp_t        sb [$];
   exp_t        mon_e;
   logic [1:0]  mon_oh;

   int          dn_addr_lat = 0;
   int          dn_data_lat = 0;
   logic [63:0] dn_rdata    = '0;
   int          bcnt        = 0;

   always #5 clk = ~clk;

   mem_bus_arbiter_if #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) mif ();

   mem_bus_arbiter #(
      .NUM_REQ (NR),
      .ADDR_W  (AW),
      .DATA_W  (DW)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .mif   (mif.master)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic nedge();
      @(negedge clk);
   endtask

   task automatic set_req(input int i, input logic [63:0] a, input logic [7:0] s, input logic [63:0] d);
      mif.req_addr[i*AW +: AW]  = a;
      mif.req_size[i*3 +: 3]    = MSIZE8;
      mif.req_strobe[i*8 +: 8]  = s;
      mif.req_data[i*DW +: DW]  = d;
   endtask

   // Called at the negedge of the first BUSY cycle; n = cycles until data_ok.
   task automatic wait_done(input int bound, output int n);
      n = 0;
      while (mif.resp_data_ok == '0 && n < bound) begin
         step();
         nedge();
         n++;
      end
      if (mif.resp_data_ok == '0) begin
         checks++;
         errors++;
         $display("FAIL wait_done: no resp_data_ok within %0d cycles", bound);
      end
   endtask

   // Downstream model: addr_ok / data_ok at fixed offsets from first bus_valid cycle.
   initial begin
      mif.bus_addr_ok = 1'b0;
      mif.bus_data_ok = 1'b0;
      mif.bus_rdata   = '0;
      forever begin
         @(posedge clk);
         #1;
         if (mif.bus_valid) begin
            mif.bus_addr_ok = (bcnt == dn_addr_lat);
            mif.bus_data_ok = (bcnt == dn_data_lat);
            mif.bus_rdata   = dn_rdata;
            bcnt++;
         end else begin
            mif.bus_addr_ok = 1'b0;
            mif.bus_data_ok = 1'b0;
            bcnt            = 0;
         end
      end
   end

   // Scoreboard monitor and requester protocol assertion
   always @(negedge clk) begin
      if (!reset && mif.resp_data_ok != '0) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected: resp_data_ok=%b with empty queue", mif.resp_data_ok);
         end else begin
            mon_e          = sb.pop_front();
            mon_oh         = '0;
            mon_oh[mon_e.id] = 1'b1;
            chk("sb_resp_data_ok", 64'(mif.resp_data_ok), 64'(mon_oh));
            chk("sb_resp_data", mif.resp_data, mon_e.data);
         end
      end
      if (!reset && mif.busy) begin
         assert (mif.req_valid[mif.grant_id])
            else $error("requester dropped req_valid while granted");
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   int n;
   int exp_seq [6];
   logic [1:0] vseq [6];

   initial begin
`ifdef MEM_BUS_ARB_RR_EN
      exp_seq = '{0, 1, 0, 1, 0, 1};
      vseq    = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11};
`else
      exp_seq = '{0, 0, 0, 0, 0, 1};
      vseq    = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b10};
`endif
      mif.req_valid  = '0;
      mif.req_addr   = '0;
      mif.req_size   = '0;
      mif.req_strobe = '0;
      mif.req_data   = '0;

      // Reset state
      step();
      step();
      nedge();
      chk("rst_bus_valid", 64'(mif.bus_valid), 64'd0);
      chk("rst_busy", 64'(mif.busy), 64'd0);
      chk("rst_resp_addr_ok", 64'(mif.resp_addr_ok), 64'd0);
      chk("rst_resp_data_ok", 64'(mif.resp_data_ok), 64'd0);
      chk("rst_grant_id", 64'(mif.grant_id), 64'd0);
      step();
      reset = 1'b0;

      // Single read from ibus, data_ok 3 cycles after bus_valid
      set_req(1, 64'h8000_0000, 8'h00, 64'h0);
      dn_addr_lat = 0; dn_data_lat = 3; dn_rdata = 64'h1234;
      sb.push_back('{id: 1, data: 64'h1234});
      mif.req_valid = 2'b10;
      nedge();
      chk("t1_idle_bus_valid", 64'(mif.bus_valid), 64'd0);
      step(); nedge();
      chk("t1_bus_valid", 64'(mif.bus_valid), 64'd1);
      chk("t1_grant", 64'(mif.grant_id), 64'd1);
      chk("t1_bus_addr", mif.bus_addr, 64'h8000_0000);
      chk("t1_bus_size", 64'(mif.bus_size), 64'(MSIZE8));
      chk("t1_resp_addr_ok", 64'(mif.resp_addr_ok), 64'b10);
      wait_done(10, n);
      chk("t1_latency", 64'(n), 64'd3);
      step(); mif.req_valid = 2'b00; nedge();
      chk("t1_busy_drop", 64'(mif.busy), 64'd0);

      // Simultaneous dbus write and ibus read, fixed start: dbus first
      step();
      set_req(0, 64'h1000, 8'hFF, 64'hDEAD);
      set_req(1, 64'h2000, 8'h00, 64'h0);
      dn_addr_lat = 0; dn_data_lat = 1; dn_rdata = 64'h5555;
      sb.push_back('{id: 0, data: 64'h5555});
      sb.push_back('{id: 1, data: 64'h5555});
      mif.req_valid = 2'b11;
      nedge();
      step(); nedge();
      chk("t2_grant0", 64'(mif.grant_id), 64'd0);
      chk("t2_strobe0", 64'(mif.bus_strobe), 64'hFF);
      chk("t2_data0", mif.bus_data, 64'hDEAD);
      chk("t2_addr0", mif.bus_addr, 64'h1000);
      wait_done(10, n);
      chk("t2_latency0", 64'(n), 64'd1);
      step(); mif.req_valid = 2'b10; nedge();
      chk("t2_bubble", 64'(mif.bus_valid), 64'd0);
      step(); nedge();
      chk("t2_bus_valid1", 64'(mif.bus_valid), 64'd1);
      chk("t2_grant1", 64'(mif.grant_id), 64'd1);
      chk("t2_strobe1", 64'(mif.bus_strobe), 64'h00);
      chk("t2_addr1", mif.bus_addr, 64'h2000);
      wait_done(10, n);
      step(); mif.req_valid = 2'b00; nedge();

      // addr_ok on first BUSY cycle, data_ok on fourth
      step();
      set_req(0, 64'h4000, 8'h00, 64'h0);
      dn_addr_lat = 0; dn_data_lat = 3; dn_rdata = 64'hA5A5;
      sb.push_back('{id: 0, data: 64'hA5A5});
      mif.req_valid = 2'b01;
      nedge();
      for (int c = 0; c < 4; c++) begin
         step(); nedge();
         chk("t3_bus_valid", 64'(mif.bus_valid), 64'd1);
         chk("t3_resp_addr_ok", 64'(mif.resp_addr_ok), (c == 0) ? 64'd1 : 64'd0);
      end
      step(); mif.req_valid = 2'b00; nedge();
      chk("t3_idle_after", 64'(mif.busy), 64'd0);

      // Same-cycle addr_ok and data_ok
      step();
      set_req(1, 64'h5000, 8'h00, 64'h0);
      dn_addr_lat = 0; dn_data_lat = 0; dn_rdata = 64'hCAFE;
      sb.push_back('{id: 1, data: 64'hCAFE});
      mif.req_valid = 2'b10;
      nedge();
      step(); nedge();
      chk("t4_resp_addr_ok", 64'(mif.resp_addr_ok), 64'b10);
      chk("t4_busy", 64'(mif.busy), 64'd1);
      step(); mif.req_valid = 2'b00; nedge();
      chk("t4_idle_next", 64'(mif.busy), 64'd0);

      // Reset mid-BUSY, then a fresh request
      step();
      set_req(0, 64'h6000, 8'h00, 64'h0);
      dn_addr_lat = 0; dn_data_lat = 20; dn_rdata = 64'h0;
      mif.req_valid = 2'b01;
      nedge();
      step(); nedge();
      chk("t5_busy", 64'(mif.busy), 64'd1);
      step(); reset = 1'b1; mif.req_valid = 2'b00; nedge();
      step(); reset = 1'b0;
      set_req(1, 64'h3000, 8'h00, 64'h0);
      dn_addr_lat = 1; dn_data_lat = 2; dn_rdata = 64'hBEEF;
      sb.push_back('{id: 1, data: 64'hBEEF});
      mif.req_valid = 2'b10;
      nedge();
      chk("t5_rst_bus_valid", 64'(mif.bus_valid), 64'd0);
      chk("t5_rst_busy", 64'(mif.busy), 64'd0);
      step(); nedge();
      chk("t5_fresh_grant", 64'(mif.grant_id), 64'd1);
      wait_done(10, n);
      chk("t5_fresh_latency", 64'(n), 64'd2);
      step(); mif.req_valid = 2'b00; nedge();

      // Continuous requests: grant sequence
      set_req(0, 64'h7000, 8'h00, 64'h0);
      set_req(1, 64'h7100, 8'h00, 64'h0);
      dn_addr_lat = 0; dn_data_lat = 0; dn_rdata = 64'h0F0F;
      for (int i = 0; i < 6; i++) begin
         step();
         mif.req_valid = vseq[i];
         sb.push_back('{id: exp_seq[i], data: 64'h0F0F});
         nedge();
         chk("t6_bubble", 64'(mif.busy), 64'd0);
         step(); nedge();
         chk("t6_grant_seq", 64'(mif.grant_id), 64'(exp_seq[i]));
      end
      step(); mif.req_valid = 2'b00; nedge();
      chk("t6_idle_end", 64'(mif.busy), 64'd0);

      repeat (3) step();
      chk("sb_empty", 64'(sb.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares one downstream memory bus among NUM_REQ pipeline requesters: core ibus fetch port, core dbus memory port, and future ports such as a page walker.
- Sits between the core's ireq/dreq ports and the single memory interface.
- Grants one requester per transaction, holds the grant until the downstream data_ok, and routes the response back to the granted requester only.
- Lets the fetch and memory stages stall on their own resp handshakes, with no knowledge of each other.

Parameters:
- NUM_REQ, 2, number of requesters; index 0 = dbus, index 1 = ibus.
- ADDR_W, 64, address width.
- DATA_W, 64, data width; strobe width = DATA_W/8.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_addr  in  NUM_REQ*ADDR_W  per-requester address.
- req_size  in  NUM_REQ*3  access size code (msize_t encoding).
- req_strobe  in  NUM_REQ*DATA_W/8  write byte strobes; all-zero = read.
- req_data  in  NUM_REQ*DATA_W  write data.
- resp_addr_ok  out  NUM_REQ  address accepted, to granted requester only.
- resp_data_ok  out  NUM_REQ  transaction complete, to granted requester only.
- resp_data  out  DATA_W  read data, broadcast; qualified by resp_data_ok.
- bus_valid  out  1  downstream request valid.
- bus_addr  out  ADDR_W  downstream address.
- bus_size  out  3  downstream size.
- bus_strobe  out  DATA_W/8  downstream strobes.
- bus_data  out  DATA_W  downstream write data.
- bus_addr_ok  in  1  downstream address accepted.
- bus_data_ok  in  1  downstream completion.
- bus_rdata  in  DATA_W  downstream read data.
- grant_id  out  $clog2(NUM_REQ)  current owner; valid while busy=1.
- busy  out  1  transaction in flight.

Behaviour:
- States: IDLE, BUSY.
- Reset: state=IDLE, grant_id=0, rr pointer=0. bus_valid, busy, resp_addr_ok and resp_data_ok are all 0 in the cycle after the reset edge.
- IDLE with any req_valid: the winner is chosen by the arbitration policy and registered into grant_id; state goes to BUSY next cycle.
- IDLE with no req_valid: stays in IDLE.
- Issue latency: request seen in IDLE at cycle t gives bus_valid=1 at cycle t+1.
- BUSY outputs:
  - bus_valid=1 and busy=1.
  - bus_addr/size/strobe/data combinationally muxed from the live inputs of requester grant_id.
  - resp_addr_ok[grant_id]=bus_addr_ok and resp_data_ok[grant_id]=bus_data_ok; all other resp bits are 0.
  - resp_data=bus_rdata.
- BUSY is left only on bus_data_ok=1, returning to IDLE. This holds even if bus_addr_ok and bus_data_ok rise in the same cycle.
- bus_addr_ok without bus_data_ok keeps BUSY with bus_valid still high, matching the hold-until-data_ok bus protocol.
- Back-to-back requests have one IDLE bubble cycle: minimum 2 cycles per transaction plus downstream latency.
- Requester rules:
  - A requester must hold req_valid and its payload stable from assertion until its resp_data_ok.
  - Dropping req_valid while granted is a protocol violation. The arbiter keeps the transaction running until bus_data_ok, and the bench flags it with an assertion.
- A requester asserting valid while another is granted waits, with resp_* = 0.
- Reset asserted mid-BUSY: the next cycle is IDLE with bus_valid=0. The downstream must also be reset.
- grant_id is held stable throughout BUSY.
- With NUM_REQ=1, the arbitration logic degenerates to always granting index 0.

Optional Feature:
- Macro: MEM_BUS_ARB_RR_EN.
- Defined: round-robin arbitration.
  - Search starts at (last_grant+1) mod NUM_REQ and wraps around.
  - last_grant updates on each IDLE→BUSY transition.
- Undefined: fixed priority, lowest index wins, so dbus beats ibus and the older instruction's memory access always proceeds first. The pointer register is not instantiated.

Decomposition:
- Package (pipes or a new arb_pkg):
  - arb_state_t enum {IDLE, BUSY}.
  - grant_idx_t sized $clog2(NUM_REQ).
  - Reuse of msize_t and strobe_t.
- Sub-module: arb_pick, a combinational picker. Inputs are req_valid and start index; outputs are winner index and any_valid. It is used by both policies; fixed priority passes start=0.

Test Plan:
- Single read, req 1 only: addr 0x8000_0000, downstream data_ok 3 cycles after bus_valid with rdata 0x1234 → bus_valid at t+1, resp_data_ok[1] pulses once with resp_data 0x1234, resp_*[0] stays 0, busy drops the next cycle.
- Simultaneous req 0 (write, strobe 0xFF, data 0xDEAD) and req 1 (read), fixed priority → req 0 granted first, bus_strobe=0xFF; req 1 issued 1 cycle after req 0's data_ok.
- MEM_BUS_ARB_RR_EN with both requesting continuously for 6 transactions → grant_id sequence 0,1,0,1,0,1.
- bus_addr_ok at cycle 1 and bus_data_ok at cycle 4 → bus_valid held for cycles 1–4, resp_addr_ok[grant] at cycle 1 only, state BUSY until data_ok.
- Same-cycle bus_addr_ok and bus_data_ok → one-cycle BUSY, correct data routed, IDLE next cycle.
- Reset pulse mid-BUSY → bus_valid=0, busy=0 next cycle; a fresh request afterwards completes normally.
